// File: rtl/intensity_meter_if.sv
// Sample-input and display-output bundle of the intensity meter.
// The bench drives it through master; the meter uses slave.
interface intensity_meter_if #(
    parameter int DATA_W = 16,
    parameter int LEDS   = 8
);
    localparam int LVL_W = $clog2(LEDS + 1);

    logic                     sample_valid;
    logic signed [DATA_W-1:0] sample;
    logic                     mode;
    logic [LEDS-1:0]          leds;
    logic [LVL_W-1:0]         level;
    logic                     update;
    logic                     overrun;

    modport master (
        output sample_valid, sample, mode,
        input  leds, level, update, overrun
    );

    modport slave (
        input  sample_valid, sample, mode,
        output leds, level, update, overrun
    );
endinterface

// File: rtl/intensity_meter.sv
// Audio intensity meter: averages |sample| over a window and shows the result
// as a log2 LED bar, with an optional decaying peak-hold dot.
module intensity_meter #(
    parameter int DATA_W   = 16,
    parameter int LOG2_WIN = 8,
    parameter int LEDS     = 8,
    parameter int HOLD_WIN = 4
) (
    input  logic             clk,
    input  logic             reset,
    intensity_meter_if.slave bus
);

    localparam int M     = DATA_W - 1;
    localparam int ACC_W = M + LOG2_WIN;
    localparam int LZ_W  = $clog2(M + 1);
    localparam int LVL_W = $clog2(LEDS + 1);
    localparam int HC_W  = (HOLD_WIN > 1) ? $clog2(HOLD_WIN) : 1;

    localparam logic [M-1:0]        M_ONE     = M'(1);
    localparam logic [M-1:0]        M_ZERO    = M'(0);
    localparam logic [LZ_W-1:0]     LZ_M      = LZ_W'(M);
    localparam logic [LZ_W-1:0]     LZ_OFFS   = LZ_W'(M - LEDS);
    localparam logic [LZ_W-1:0]     LZ_LEDS   = LZ_W'(LEDS);
    localparam logic [LZ_W-1:0]     LZ_ONE    = LZ_W'(1);
    localparam logic [LVL_W-1:0]    LVL_ZERO  = LVL_W'(0);
    localparam logic [LVL_W-1:0]    LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0]    LVL_LEDS  = LVL_W'(LEDS);
    localparam logic [HC_W-1:0]     HOLD_LAST = HC_W'(HOLD_WIN - 1);
    localparam logic [HC_W-1:0]     HC_ZERO   = HC_W'(0);
    localparam logic [HC_W-1:0]     HC_ONE    = HC_W'(1);
    localparam logic [LOG2_WIN-1:0] CNT_ONE   = LOG2_WIN'(1);
    localparam logic [LOG2_WIN-1:0] CNT_LAST  = {LOG2_WIN{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [LOG2_WIN-1:0] r_cnt;
    logic [M-1:0]       r_shreg;
    logic [LZ_W-1:0]    r_lz;
    logic [LVL_W-1:0]   r_peak;
    logic [HC_W-1:0]    r_hold;
    logic [LEDS-1:0]    r_leds;
    logic [LVL_W-1:0]   r_level;
    logic               r_update;
    logic               r_overrun;

    logic [M-1:0]       w_mag;
    logic [ACC_W-1:0]   w_sum;
    logic [M-1:0]       w_avg;
    logic               w_last;
    logic               w_snap;
    logic [LZ_W-1:0]    w_bitlen;
    logic [LZ_W-1:0]    w_bar_wide;
    logic [LVL_W-1:0]   w_bar;
    logic [LVL_W-1:0]   w_peak_nx;
    logic [HC_W-1:0]    w_hold_nx;
    logic [LEDS-1:0]    w_leds_nx;

    // Magnitude in M bits; the lone negative value without a positive twin saturates.
    always_comb begin
        if (bus.sample[DATA_W-1]) begin
            if (bus.sample[M-1:0] == M_ZERO) begin
                w_mag = {M{1'b1}};
            end else begin
                w_mag = ~bus.sample[M-1:0] + M_ONE;
            end
        end else begin
            w_mag = bus.sample[M-1:0];
        end
    end

    assign w_sum  = r_acc + {{LOG2_WIN{1'b0}}, w_mag};
    assign w_avg  = w_sum[ACC_W-1:LOG2_WIN];
    assign w_last = (r_cnt == CNT_LAST);
    assign w_snap = bus.sample_valid && w_last;

    // Window accumulation; the last sample of a window folds into the snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= {ACC_W{1'b0}};
            r_cnt <= {LOG2_WIN{1'b0}};
        end else if (bus.sample_valid) begin
            r_cnt <= r_cnt + CNT_ONE;
            if (w_last) begin
                r_acc <= {ACC_W{1'b0}};
            end else begin
                r_acc <= w_sum;
            end
        end else begin
            r_acc <= r_acc;
            r_cnt <= r_cnt;
        end
    end

    assign w_bitlen = LZ_M - r_lz;

    // Bar length: the top LEDS bit positions of the average map onto the bar.
    always_comb begin
        if (w_bitlen > LZ_OFFS) begin
            w_bar_wide = w_bitlen - LZ_OFFS;
        end else begin
            w_bar_wide = {LZ_W{1'b0}};
        end
        if (w_bar_wide > LZ_LEDS) begin
            w_bar = LVL_LEDS;
        end else begin
            w_bar = w_bar_wide[LVL_W-1:0];
        end
    end

    // Peak-hold bookkeeping for the result about to be displayed.
    always_comb begin
        if (w_bar >= r_peak) begin
            w_peak_nx = w_bar;
            w_hold_nx = HC_ZERO;
        end else if ((r_hold == HOLD_LAST) && (r_peak != LVL_ZERO)) begin
            w_peak_nx = r_peak - LVL_ONE;
            w_hold_nx = HC_ZERO;
        end else begin
            w_peak_nx = r_peak;
            w_hold_nx = r_hold + HC_ONE;
        end
    end

    // Thermometer bar plus the optional dot at the (updated) peak position.
    always_comb begin
        w_leds_nx = {LEDS{1'b0}};
        for (int i = 0; i < LEDS; i++) begin
            if (LVL_W'(i) < w_bar) begin
                w_leds_nx[i] = 1'b1;
            end else if (bus.mode && (w_peak_nx == LVL_W'(i + 1))) begin
                w_leds_nx[i] = 1'b1;
            end else begin
                w_leds_nx[i] = 1'b0;
            end
        end
    end

    // Result FSM: leading-zero scan of the snapshot, then display update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shreg   <= {M{1'b0}};
            r_lz      <= {LZ_W{1'b0}};
            r_peak    <= LVL_ZERO;
            r_hold    <= HC_ZERO;
            r_leds    <= {LEDS{1'b0}};
            r_level   <= LVL_ZERO;
            r_update  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_update  <= 1'b0;
            r_overrun <= w_snap && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_snap) begin
                        r_shreg <= w_avg;
                        r_lz    <= {LZ_W{1'b0}};
                        r_state <= SCAN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SCAN: begin
                    if (r_shreg == M_ZERO) begin
                        r_lz    <= LZ_M;
                        r_state <= OUTPUT;
                    end else if (!r_shreg[M-1]) begin
                        r_shreg <= {r_shreg[M-2:0], 1'b0};
                        r_lz    <= r_lz + LZ_ONE;
                        r_state <= SCAN;
                    end else begin
                        r_state <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    r_level  <= w_bar;
                    r_leds   <= w_leds_nx;
                    r_update <= 1'b1;
                    r_peak   <= w_peak_nx;
                    r_hold   <= w_hold_nx;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.leds    = r_leds;
    assign bus.level   = r_level;
    assign bus.update  = r_update;
    assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_intensity_meter.sv
// Bench for intensity_meter: two instances (256- and 16-sample windows)
// checked against a window-level reference model of averages, bars and peaks.
module tb_intensity_meter;

    localparam int DW   = 16;
    localparam int M    = DW - 1;
    localparam int LEDS = 8;
    localparam int HOLD = 4;
    localparam int LW0  = 8;
    localparam int LW1  = 4;

    typedef struct packed {
        int     dut;
        longint at;
        int     level;
        int     leds;
    } ev_t;

    logic   clk   = 1'b0;
    logic   reset = 1'b0;
    longint cyc   = 0;
    int     checks = 0;
    int     errors = 0;
    int     exp_ovr = 0;
    int     obs_ovr = 0;
    ev_t    exp_q[$];
    ev_t    obs_q[$];

    longint m_acc[2];
    int     m_cnt[2];
    longint m_busy[2];
    int     m_peak[2];
    int     m_hold[2];

    always #5 clk = ~clk;

    intensity_meter_if #(.DATA_W(DW), .LEDS(LEDS)) bus0 ();
    intensity_meter_if #(.DATA_W(DW), .LEDS(LEDS)) bus1 ();

    intensity_meter #(.DATA_W(DW), .LOG2_WIN(LW0), .LEDS(LEDS), .HOLD_WIN(HOLD)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    intensity_meter #(.DATA_W(DW), .LOG2_WIN(LW1), .LEDS(LEDS), .HOLD_WIN(HOLD)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    always @(posedge clk) cyc <= cyc + 1;

    // Record every update pulse (with the edge it came from) and count overruns.
    always @(negedge clk) begin
        if (bus0.update === 1'b1) obs_q.push_back('{0, cyc, int'(bus0.level), int'(bus0.leds)});
        if (bus1.update === 1'b1) obs_q.push_back('{1, cyc, int'(bus1.level), int'(bus1.leds)});
        obs_ovr <= obs_ovr + int'(bus0.overrun === 1'b1) + int'(bus1.overrun === 1'b1);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, need one");
        $fatal(1, "watchdog");
    end

    function automatic int mag_of(int x);
        if (x == -32768) return 32767;
        return (x < 0) ? -x : x;
    endfunction

    function automatic int bits_of(longint v);
        int n = 0;
        while (v > 0) begin
            n++;
            v = v >> 1;
        end
        return n;
    endfunction

    // Reference model: whole-window average, log2 bar, peak rules, busy window.
    task automatic model_accept(int d, int x, longint e);
        int lw, bl, bar, lv, md;
        longint avg, done;
        lw = (d == 1) ? LW1 : LW0;
        m_acc[d] += mag_of(x);
        m_cnt[d]++;
        if (m_cnt[d] == (1 << lw)) begin
            avg = m_acc[d] >> lw;
            m_acc[d] = 0;
            m_cnt[d] = 0;
            if (e <= m_busy[d]) begin
                exp_ovr++;
            end else begin
                bl   = bits_of(avg);
                done = (avg == 0) ? e + 2 : e + (M - bl) + 2;
                m_busy[d] = done;
                bar = bl - (M - LEDS);
                if (bar < 0) bar = 0;
                if (bar > LEDS) bar = LEDS;
                if (bar >= m_peak[d]) begin
                    m_peak[d] = bar;
                    m_hold[d] = 0;
                end else if (m_hold[d] == HOLD - 1 && m_peak[d] > 0) begin
                    m_peak[d]--;
                    m_hold[d] = 0;
                end else begin
                    m_hold[d]++;
                end
                lv = (1 << bar) - 1;
                md = (d == 1) ? int'(bus1.mode) : int'(bus0.mode);
                if (md == 1 && m_peak[d] > 0) lv = lv | (1 << (m_peak[d] - 1));
                exp_q.push_back('{d, done, bar, lv});
            end
        end
    endtask

    task automatic drive(int d, bit v, int x);
        @(negedge clk);
        if (d == 0) begin
            bus0.sample_valid = v;
            bus0.sample       = 16'(x);
        end else begin
            bus1.sample_valid = v;
            bus1.sample       = 16'(x);
        end
        if (v && !reset) model_accept(d, x, cyc + 1);
    endtask

    task automatic drive_n(int d, int n, int x);
        for (int i = 0; i < n; i++) drive(d, 1'b1, x);
    endtask

    // Reset for n edges with a loud sample offered to both meters.
    task automatic do_reset(int n);
        ev_t keep[$];
        longint r0;
        @(negedge clk);
        reset = 1'b1;
        bus0.sample_valid = 1'b1; bus0.sample = 16'sh7FFF;
        bus1.sample_valid = 1'b1; bus1.sample = 16'sh7FFF;
        r0 = cyc + 1;
        foreach (exp_q[i]) if (exp_q[i].at < r0) keep.push_back(exp_q[i]);
        exp_q = keep;
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = 0; m_cnt[d] = 0; m_busy[d] = 0; m_peak[d] = 0; m_hold[d] = 0;
        end
        repeat (n) @(negedge clk);
        reset = 1'b0;
        bus0.sample_valid = 1'b0;
        bus1.sample_valid = 1'b0;
    endtask

    task automatic settle(output bit ok);
        int n = 0;
        while (obs_q.size() < exp_q.size() && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (24) @(negedge clk);
        ok = (obs_q.size() >= exp_q.size());
    endtask

    task automatic test_reset();
        do_reset(3);
        checks++;
        if (bus0.leds !== 8'h00 || bus0.level !== 4'd0 || bus0.update !== 1'b0 || bus0.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut0: got leds %0h level %0d upd %0b ovr %0b, need all 0",
                     bus0.leds, bus0.level, bus0.update, bus0.overrun);
        end
        checks++;
        if (bus1.leds !== 8'h00 || bus1.level !== 4'd0 || bus1.update !== 1'b0 || bus1.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut1: got leds %0h level %0d upd %0b ovr %0b, need all 0",
                     bus1.leds, bus1.level, bus1.update, bus1.overrun);
        end
    endtask

    // One full window of a constant; compared against the model and a fixed bar.
    task automatic test_window(string name, int x, int want_level, int want_leds);
        bit ok;
        ev_t o, e, last;
        int n = 0;
        last = '{-1, -1, -1, -1};
        do_reset(2);
        bus0.mode = 1'b0;
        drive_n(0, 256, x);
        drive(0, 1'b0, 0);
        settle(ok);
        checks++;
        if (!ok || obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d updates, need %0d", name, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); last = o; n++;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s_update: got dut%0d edge %0d level %0d leds %0h, need dut%0d edge %0d level %0d leds %0h",
                         name, o.dut, o.at, o.level, o.leds, e.dut, e.at, e.level, e.leds);
            end
        end
        obs_q.delete(); exp_q.delete();
        checks++;
        if (n !== 1 || last.level !== want_level || last.leds !== want_leds) begin
            errors++;
            $display("FAIL %s_fixed: got %0d updates level %0d leds %0h, need 1 update level %0d leds %0h",
                     name, n, last.level, last.leds, want_level, want_leds);
        end
    endtask

    task automatic test_peak_hold();
        bit ok;
        ev_t o, e;
        int lv[$];
        do_reset(2);
        bus0.mode = 1'b1;
        drive_n(0, 256, 32767);
        for (int w = 0; w < 24; w++) drive_n(0, 256, 256);
        drive(0, 1'b0, 0);
        settle(ok);
        checks++;
        if (!ok || obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL peak_count: got %0d updates, need %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); lv.push_back(o.leds);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL peak_update: got edge %0d level %0d leds %0h, need edge %0d level %0d leds %0h",
                         o.at, o.level, o.leds, e.at, e.level, e.leds);
            end
        end
        obs_q.delete(); exp_q.delete();
        checks++;
        if (lv.size() !== 25 || lv[0] !== 'hFF || lv[1] !== 'h83 || lv[3] !== 'h83 || lv[4] !== 'h43
            || lv[7] !== 'h43 || lv[8] !== 'h23 || lv[12] !== 'h13) begin
            errors++;
            $display("FAIL peak_fixed: got n=%0d w1 %0h w2 %0h w4 %0h w5 %0h w8 %0h w9 %0h w13 %0h, need 25 FF 83 83 43 43 23 13",
                     lv.size(), lv[0], lv[1], lv[3], lv[4], lv[7], lv[8], lv[12]);
        end
    endtask

    task automatic test_random();
        bit ok, v;
        ev_t o, e;
        int k, x, got;
        do_reset(2);
        bus0.mode = 1'($urandom_range(0, 1));
        for (int w = 0; w < 6; w++) begin
            k = $urandom_range(0, 15);
            got = 0;
            while (got < 256) begin
                v = ($urandom_range(0, 3) != 0);
                x = $urandom_range(0, 1 << k);
                if ($urandom_range(0, 1) == 1) x = -x;
                else if (x > 32767) x = 32767;
                drive(0, v, x);
                if (v) got++;
            end
        end
        drive(0, 1'b0, 0);
        settle(ok);
        checks++;
        if (!ok || obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d updates, need %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random_update: got edge %0d level %0d leds %0h, need edge %0d level %0d leds %0h",
                         o.at, o.level, o.leds, e.at, e.level, e.leds);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    // 16-sample windows with valid held high: slow results force dropped windows.
    task automatic test_back_to_back();
        bit ok;
        ev_t o, e, last;
        int ovr0, n = 0;
        last = '{-1, -1, -1, -1};
        do_reset(2);
        bus1.mode = 1'b0;
        ovr0 = obs_ovr;
        drive_n(1, 96, 1);
        drive_n(1, 32, 256);
        drive(1, 1'b0, 0);
        settle(ok);
        checks++;
        if (!ok || obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d updates, need %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); last = o; n++;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_update: got dut%0d edge %0d level %0d leds %0h, need dut%0d edge %0d level %0d leds %0h",
                         o.dut, o.at, o.level, o.leds, e.dut, e.at, e.level, e.leds);
            end
        end
        obs_q.delete(); exp_q.delete();
        checks++;
        if (obs_ovr !== exp_ovr) begin
            errors++;
            $display("FAIL b2b_overrun_model: got %0d overruns, need %0d", obs_ovr, exp_ovr);
        end
        checks++;
        if (obs_ovr - ovr0 !== 3 || n !== 5 || last.level !== 2 || last.leds !== 'h03) begin
            errors++;
            $display("FAIL b2b_fixed: got ovr %0d upd %0d level %0d leds %0h, need ovr 3 upd 5 level 2 leds 3",
                     obs_ovr - ovr0, n, last.level, last.leds);
        end
    endtask

    task automatic test_reset_midwindow();
        bit ok;
        ev_t o;
        test_window("pre_reset", 256, 2, 'h03);
        drive_n(0, 255, 256);
        drive_n(0, 1, 1);
        do_reset(2);
        checks++;
        if (bus0.leds !== 8'h00 || bus0.level !== 4'd0) begin
            errors++;
            $display("FAIL inflight_reset_out: got leds %0h level %0d, need 0 0", bus0.leds, bus0.level);
        end
        drive_n(0, 100, 256);
        do_reset(2);
        settle(ok);
        checks++;
        if (obs_q.size() !== 0 || exp_q.size() !== 0 || bus0.leds !== 8'h00 || bus0.level !== 4'd0) begin
            errors++;
            $display("FAIL partial_reset: got %0d updates leds %0h level %0d, need 0 updates leds 0 level 0",
                     obs_q.size(), bus0.leds, bus0.level);
        end
        obs_q.delete(); exp_q.delete();
        drive_n(0, 256, 256);
        drive(0, 1'b0, 0);
        settle(ok);
        checks++;
        if (!ok || obs_q.size() !== 1) begin
            errors++;
            $display("FAIL post_reset_count: got %0d updates, need 1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++;
            if (o.level !== 2 || o.leds !== 'h03) begin
                errors++;
                $display("FAIL post_reset_window: got level %0d leds %0h, need level 2 leds 3", o.level, o.leds);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        bus0.sample_valid = 1'b0; bus0.sample = 16'sd0; bus0.mode = 1'b0;
        bus1.sample_valid = 1'b0; bus1.sample = 16'sd0; bus1.mode = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = 0; m_cnt[d] = 0; m_busy[d] = 0; m_peak[d] = 0; m_hold[d] = 0;
        end
        test_reset();
        test_window("pos256", 256, 2, 'h03);
        test_window("neg256", -256, 2, 'h03);
        test_window("most_neg", -32768, 8, 'hFF);
        test_window("small127", 127, 0, 'h00);
        test_peak_hold();
        test_random();
        test_back_to_back();
        test_reset_midwindow();
        checks++;
        if (obs_ovr !== exp_ovr) begin
            errors++;
            $display("FAIL overrun_total: got %0d overruns, need %0d", obs_ovr, exp_ovr);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intensity_meter.md
INTENSITY_METER -- requirements
Module: intensity_meter

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed two's-complement sample width, minimum 4.
REQ-002 SHALL have parameter LOG2_WIN, default 8: averaging window of 2^LOG2_WIN accepted samples, minimum 4.
REQ-003 SHALL have parameter LEDS, default 8: bar length, 1 <= LEDS <= M, where M = DATA_W-1.
REQ-004 SHALL have parameter HOLD_WIN, default 4: windows a peak is held before it decays, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port sample_valid, input, 1 bit: sample is accepted on any edge where this is high.
REQ-008 SHALL have port sample, input, DATA_W bits: signed audio sample.
REQ-009 SHALL have port mode, input, 1 bit: 0 = bar only, 1 = bar plus peak-hold dot.
REQ-010 SHALL have port leds, output, LEDS bits, registered: thermometer display, LSB first.
REQ-011 SHALL have port level, output, clog2(LEDS+1) bits, registered: lit bar count.
REQ-012 SHALL have port update, output, 1 bit: one-cycle pulse when leds and level change.
REQ-013 SHALL have port overrun, output, 1 bit: one-cycle pulse when a window result is dropped.

Function
REQ-014 SHALL form the magnitude of each accepted sample as |sample|.
REQ-015 SHALL saturate the magnitude of the most-negative sample to 2^M-1.
REQ-016 SHALL add each magnitude into an accumulator of M+LOG2_WIN bits that never overflows.
REQ-017 SHALL keep a window counter of LOG2_WIN bits that increments per accepted sample and wraps to 0.
REQ-018 SHALL, on the edge accepting the 2^LOG2_WIN-th sample, snapshot avg = (acc + magnitude) >> LOG2_WIN (M bits), clear acc to 0, and start the next window with no sample lost.
REQ-019 SHALL run a processing FSM with states IDLE, SCAN, OUTPUT, decoupled from accumulation.
REQ-020 SHALL, in IDLE, load avg into the shift register, clear lz, and go to SCAN on snapshot.
REQ-021 SHALL, in SCAN with shreg == 0, set lz = M and go to OUTPUT.
REQ-022 SHALL, in SCAN with shreg MSB == 0, shift shreg left one bit, increment lz, and stay in SCAN.
REQ-023 SHALL, in SCAN with shreg MSB == 1, go to OUTPUT.
REQ-024 SHALL compute bitlen = M - lz.
REQ-025 SHALL compute bar = max(0, bitlen - (M - LEDS)), clamped to LEDS.
REQ-026 SHALL, in OUTPUT, register level = bar and assert update for one cycle, then return to IDLE.
REQ-027 SHALL, in OUTPUT, register leds with the low bar bits set.
REQ-028 SHALL, in OUTPUT with mode = 1 and peak > 0, also set leds bit peak-1.
REQ-029 SHALL sample mode only in OUTPUT.
REQ-030 SHALL update the peak in OUTPUT: if bar >= peak, set peak = bar and hold_cnt = 0.
REQ-031 SHALL otherwise, if hold_cnt == HOLD_WIN-1 and peak > 0, decrement peak by 1 and set hold_cnt = 0.
REQ-032 SHALL otherwise increment hold_cnt.
REQ-033 SHALL track the peak in both modes.
REQ-034 SHALL give a worst-case latency of update at or before edge T+M+2, where T is the snapshot edge.
REQ-035 SHALL, on a snapshot while the FSM is not IDLE, drop the new result, pulse overrun, leave accumulation unaffected, and let the in-flight result complete.
REQ-036 SHALL give sample_valid low no effect on acc or the counter.
REQ-037 SHALL let the FSM run regardless of sample_valid.

Reset
REQ-038 SHALL, on reset high at an edge, clear acc, the counter, shreg, lz, peak, hold_cnt, leds, level, update and overrun to 0, and set the FSM to IDLE.
REQ-039 SHALL discard a partial window or an in-flight result on reset, with no update following.
REQ-040 SHALL ignore a sample presented with sample_valid in a reset cycle.

Verification
REQ-041 SHALL cover: defaults, 256 samples of 0x0100 -> level 2, leds 0x03, one update pulse.
REQ-042 SHALL cover: 256 samples of 0xFF00 (-256) -> level 2, leds 0x03 (sign handled).
REQ-043 SHALL cover: 256 samples of 0x8000 -> level 8, leds 0xFF; 256 samples of 0x007F -> level 0, leds 0x00, update still pulses.
REQ-044 SHALL cover: mode = 1, one window at 0x7FFF, then windows of 0x0100 -> leds 0x83 for 3 windows, 0x43 at window 5, decays one position per 4 windows thereafter.
REQ-045 SHALL cover: LOG2_WIN = 4, sample_valid held high -> overrun pulses, accumulation continues, the next accepted window updates correctly.
REQ-046 SHALL cover: reset asserted after 100 samples -> outputs 0, no update; a following full window of 0x0100 gives level 2.
